// File: rtl/accum_reduce_pkg.sv
// Shared definitions for the accum_reduce functional unit: FSM state encodings
// and memory-mapped register addresses (decoded on addr[0] only).
package accum_reduce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ACC   = 2'd2
  } state_t;

  localparam logic ACC_ADDR_SUM = 1'b0;
  localparam logic ACC_ADDR_CNT = 1'b1;

endpackage

// File: rtl/accum_reduce_iter_cnt.sv
// accum_iter_cnt: nested per/iter counter loaded on run; flags the first and last
// sample of each period and the last sample of the whole run.
module accum_iter_cnt #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] per,
  input  logic [CNT_W-1:0] iter,
  output logic             first_of_period,
  output logic             last_of_period,
  output logic             last_of_run
);

  logic [CNT_W-1:0] per_r;
  logic [CNT_W-1:0] iter_r;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] iter_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      per_r    <= '0;
      iter_r   <= '0;
      per_cnt  <= '0;
      iter_cnt <= '0;
    end else if (load) begin
      per_r    <= per;
      iter_r   <= iter;
      per_cnt  <= '0;
      iter_cnt <= '0;
    end else if (en) begin
      if (last_of_period) begin
        per_cnt  <= '0;
        iter_cnt <= iter_cnt + CNT_W'(1);
      end else begin
        per_cnt  <= per_cnt + CNT_W'(1);
      end
    end
  end

  assign first_of_period = (per_cnt == '0);
  assign last_of_period  = (per_cnt == per_r - CNT_W'(1));
  assign last_of_run     = last_of_period && (iter_cnt == iter_r - CNT_W'(1));

endmodule

// File: rtl/accum_reduce.sv
// accum_reduce: sums PER consecutive in0 samples per period, ITER periods per run,
// with memory-mapped readback. Define ACCUM_SAT_EN for signed saturating addition.
module accum_reduce
  import accum_reduce_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  output logic                     done,
  input  logic signed [DATA_W-1:0] in0,
  output logic signed [DATA_W-1:0] out0,
  input  logic [CNT_W-1:0]         iter,
  input  logic [CNT_W-1:0]         per,
  input  logic [31:0]              delay0,
  input  logic                     valid,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     ready,
  output logic [DATA_W-1:0]        rdata
);

  function automatic logic signed [DATA_W-1:0] add_fn(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] s;
    s = a + b;
`ifdef ACCUM_SAT_EN
    if ((a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]))
      s = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
    return s;
  endfunction

  state_t                   state;
  logic signed [DATA_W-1:0] acc;
  logic signed [DATA_W-1:0] last_sum;
  logic signed [DATA_W-1:0] period_sum;
  logic [CNT_W-1:0]         count;
  logic                     accept, acc_en, dly_en, period_end, mm_clr;
  logic                     first_s, last_per, last_run;
  logic                     dly_first, dly_last_per, dly_end;
  logic                     unused_bits;

  assign accept     = run && (state == ST_IDLE) && (iter != '0) && (per != '0);
  assign acc_en     = (state == ST_ACC);
  assign dly_en     = (state == ST_DELAY);
  assign period_end = acc_en && last_per;
  assign mm_clr     = valid && (|wstrb);
  assign period_sum = first_s ? in0 : add_fn(acc, in0);
  assign unused_bits = ^{wdata, addr[ADDR_W-1:1], dly_first, dly_last_per};

  accum_iter_cnt #(.CNT_W(CNT_W)) u_acc_cnt (
    .clk             (clk),
    .rst             (rst),
    .load            (accept),
    .en              (acc_en),
    .per             (per),
    .iter            (iter),
    .first_of_period (first_s),
    .last_of_period  (last_per),
    .last_of_run     (last_run)
  );

  // Single-level instance: one "period" of delay0 cycles marks the end of DELAY.
  accum_iter_cnt #(.CNT_W(32)) u_dly_cnt (
    .clk             (clk),
    .rst             (rst),
    .load            (accept),
    .en              (dly_en),
    .per             (delay0),
    .iter            (32'd1),
    .first_of_period (dly_first),
    .last_of_period  (dly_last_per),
    .last_of_run     (dly_end)
  );

  always_ff @(posedge clk) begin
    if (acc_en) acc <= period_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      done     <= 1'b1;
      out0     <= '0;
      last_sum <= '0;
      count    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            done  <= 1'b0;
            state <= (delay0 == 32'd0) ? ST_ACC : ST_DELAY;
          end
        end
        ST_DELAY: if (dly_end) state <= ST_ACC;
        ST_ACC: begin
          if (last_run) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
      endcase
      // A period-end update takes priority over a same-edge MMIO clear.
      if (period_end) begin
        out0     <= period_sum;
        last_sum <= period_sum;
        count    <= (count == '1) ? count : count + CNT_W'(1);
      end else if (mm_clr) begin
        last_sum <= '0;
        count    <= '0;
      end else if (accept) begin
        count    <= '0;
      end
    end
  end

  logic [DATA_W-1:0] rd_sel;

  always_comb begin
    rd_sel = '0;
    case (addr[0])
      ACC_ADDR_SUM: rd_sel = last_sum;
      ACC_ADDR_CNT: rd_sel = {{(DATA_W-CNT_W){1'b0}}, count};
      default:      rd_sel = '0;
    endcase
  end

  // MMIO response stage: acknowledge exactly one cycle after each request.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= valid;
      rdata <= (valid && !(|wstrb)) ? rd_sel : '0;
    end
  end

endmodule

// File: tb/tb_accum_reduce.sv
// Scoreboard bench for accum_reduce: stimulus schedules timed expectations,
// a negedge monitor compares out0/done/ready/rdata when each one comes due.
module tb_accum_reduce;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 10;
  localparam int K_OUT0 = 0, K_DONE = 1, K_READY = 2, K_RDATA = 3;
`ifdef ACCUM_SAT_EN
  localparam logic [31:0] SUMX = 32'h7fff_ffff;
`else
  localparam logic [31:0] SUMX = 32'h8000_0000;
`endif

  logic clk = 1'b0;
  logic rst, run, done, valid, ready;
  logic signed [DATA_W-1:0] in0, out0;
  logic [CNT_W-1:0] iter, per;
  logic [31:0] delay0;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0] wdata, rdata;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int e;
  logic [31:0] act;

  typedef struct {int cyc; int kind; logic [31:0] val;} exp_t;
  exp_t sb[$];

  accum_reduce #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .done(done), .in0(in0), .out0(out0),
    .iter(iter), .per(per), .delay0(delay0), .valid(valid), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .ready(ready), .rdata(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_OUT0:  return "out0";
      K_DONE:  return "done";
      K_READY: return "ready";
      default: return "rdata";
    endcase
  endfunction

  function automatic void exp_at(input int c, input int k, input logic [31:0] v);
    exp_t x;
    x.cyc = c; x.kind = k; x.val = v;
    sb.push_back(x);
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_OUT0:  act = out0;
          K_DONE:  act = {31'b0, done};
          K_READY: act = {31'b0, ready};
          default: act = rdata;
        endcase
        total++;
        if (act !== sb[i].val) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%h want=%h", kname(sb[i].kind), cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go(input int it, input int pe, input int d);
    iter = CNT_W'(it); per = CNT_W'(pe); delay0 = d; run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic feed(input logic [31:0] v);
    in0 = v;
    tick();
  endtask

  // One MMIO access; last=1 also expects ready to drop the cycle after.
  task automatic mm(input bit wr, input bit a, input logic [31:0] v, input bit last);
    exp_at(cyc + 1, K_READY, 32'd1);
    exp_at(cyc + 1, K_RDATA, v);
    if (last) exp_at(cyc + 2, K_READY, 32'd0);
    valid = 1'b1; addr = {{(ADDR_W-1){1'b0}}, a}; wstrb = wr ? '1 : '0;
    wdata = 32'hdead_beef;
    tick();
    valid = 1'b0; wstrb = '0;
  endtask

  task automatic run_wrap();
    e = cyc + 1;
    exp_at(e, K_DONE, 32'd0);
    exp_at(e + 4, K_OUT0, 32'd10);
    exp_at(e + 7, K_DONE, 32'd0);
    exp_at(e + 8, K_OUT0, 32'd26);
    exp_at(e + 8, K_DONE, 32'd1);
    go(2, 4, 0);
    for (int v = 1; v <= 8; v++) feed(v);
    in0 = 32'h0bad_0bad;
    tick();
    mm(1'b0, 1'b1, 32'd2, 1'b0);
    mm(1'b0, 1'b0, 32'd26, 1'b1);
    tick();
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; valid = 1'b0; addr = '0; wstrb = '0; wdata = '0;
    in0 = '0; iter = '0; per = '0; delay0 = '0;
    repeat (3) tick();
    exp_at(cyc + 1, K_DONE, 32'd1);
    exp_at(cyc + 1, K_OUT0, 32'd0);
    exp_at(cyc + 1, K_READY, 32'd0);
    exp_at(cyc + 1, K_RDATA, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // wrapping sums over two periods, then readback
    run_wrap();

    // write clears last_sum and count; back-to-back accesses
    mm(1'b1, 1'b0, 32'd0, 1'b0);
    mm(1'b0, 1'b0, 32'd0, 1'b0);
    mm(1'b0, 1'b1, 32'd0, 1'b1);
    tick();

    // programmed delay: junk before the first consumed sample
    e = cyc + 1;
    exp_at(e + 4, K_OUT0, 32'd26);
    exp_at(e + 4, K_DONE, 32'd0);
    exp_at(e + 5, K_OUT0, 32'd16);
    exp_at(e + 5, K_DONE, 32'd1);
    go(1, 2, 3);
    feed(32'd100); feed(32'd200); feed(32'd300); feed(32'd7); feed(32'd9);
    in0 = 32'd55;
    repeat (2) tick();

    // degenerate configurations leave everything untouched
    e = cyc + 1;
    exp_at(e, K_DONE, 32'd1);
    exp_at(e, K_OUT0, 32'd16);
    go(3, 0, 2);
    e = cyc + 1;
    exp_at(e, K_DONE, 32'd1);
    exp_at(e + 1, K_OUT0, 32'd16);
    go(0, 4, 0);
    tick();
    mm(1'b0, 1'b1, 32'd1, 1'b1);
    tick();

    // run while accumulating is ignored
    e = cyc + 1;
    exp_at(e + 2, K_DONE, 32'd0);
    exp_at(e + 3, K_OUT0, 32'd6);
    exp_at(e + 3, K_DONE, 32'd1);
    exp_at(e + 5, K_OUT0, 32'd6);
    exp_at(e + 5, K_DONE, 32'd1);
    go(1, 3, 0);
    feed(32'd1);
    run = 1'b1; iter = CNT_W'(5); per = CNT_W'(1);
    feed(32'd2);
    run = 1'b0;
    feed(32'd3);
    in0 = 32'd50;
    repeat (3) tick();
    mm(1'b0, 1'b1, 32'd1, 1'b1);
    tick();

    // overflow at the positive rail, with a clear on the period-end edge
    e = cyc + 1;
    exp_at(e + 2, K_OUT0, SUMX);
    go(1, 2, 0);
    feed(32'h7fff_ffff);
    in0 = 32'd1;
    mm(1'b1, 1'b0, 32'd0, 1'b0);
    in0 = 32'd0;
    mm(1'b0, 1'b0, SUMX, 1'b0);
    mm(1'b0, 1'b1, 32'd1, 1'b1);
    tick();

    // reset mid-run aborts, then a fresh run reproduces the wrap results
    e = cyc + 1;
    exp_at(e + 2, K_DONE, 32'd0);
    exp_at(e + 3, K_DONE, 32'd1);
    exp_at(e + 3, K_OUT0, 32'd0);
    exp_at(e + 5, K_OUT0, 32'd0);
    exp_at(e + 6, K_DONE, 32'd1);
    go(2, 4, 0);
    feed(32'd1); feed(32'd2);
    rst = 1'b1;
    feed(32'd3);
    rst = 1'b0;
    for (int v = 4; v <= 8; v++) feed(v);
    mm(1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    run_wrap();

    repeat (3) tick();
    if (sb.size() != 0) begin
      bad += sb.size();
      $display("FAIL leftover expectations=%0d", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
